// File: rtl/bit_plane_decoder.sv
// bit_plane_decoder
//   Receive-side partner of bit_plane_coder. Pops {cx,bit} decision pairs from the
//   decision FIFO and rebuilds one 3x3 group of nine WIDTH-bit unsigned coefficients.
//   The stream runs from plane WIDTH-1 down to plane 0. Within each plane it runs
//   from coefficient 0 to coefficient 8, so one group is 9*WIDTH pairs.
//
// Ports
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   start              1-cycle pulse; begins a group, accepted only when idle
//   subband            subband tag, latched on an accepted start
//   rdempty            decision FIFO empty
//   rdreq              FIFO read request (q valid the cycle after)
//   bit_in, cx_in      decision bit / context from FIFO q
//   data0..data8       reconstructed coefficients, held until the next accepted start
//   subband_out        latched subband tag
//   output_valid       1-cycle pulse when data0..8 are complete
//   busy               high while reading or draining
//   decode_err         sticky abort/timeout flag, cleared by the next accepted start

module bit_plane_decoder #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [3:0]  ABORT_CX    = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       subband,
  input  logic             rdempty,
  output logic             rdreq,
  input  logic             bit_in,
  input  logic [3:0]       cx_in,
  output logic [WIDTH-1:0] data0,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] data3,
  output logic [WIDTH-1:0] data4,
  output logic [WIDTH-1:0] data5,
  output logic [WIDTH-1:0] data6,
  output logic [WIDTH-1:0] data7,
  output logic [WIDTH-1:0] data8,
  output logic [2:0]       subband_out,
  output logic             output_valid,
  output logic             busy,
  output logic             decode_err
);

  localparam int unsigned NumPairs = 9 * WIDTH;
  localparam int unsigned PlaneW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned IssW     = $clog2(NumPairs + 1);
  localparam int unsigned ToW      = $clog2(TIMEOUT_CYC + 1);

  localparam logic [IssW-1:0]   NumPairsW = IssW'(NumPairs);
  localparam logic [IssW-1:0]   LastIss   = IssW'(NumPairs - 1);
  localparam logic [ToW-1:0]    ToLast    = ToW'(TIMEOUT_CYC - 1);
  localparam logic [PlaneW-1:0] TopPlane  = PlaneW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                   state_q, state_d;
  logic [PlaneW-1:0]        plane_q, plane_d;
  logic [3:0]               idx_q, idx_d;
  logic [IssW-1:0]          issued_q, issued_d;
  logic [ToW-1:0]           to_q, to_d;
  logic                     rd_d1_q;
  logic                     err_q, err_d;
  logic [2:0]               sb_q, sb_d;
  logic [8:0][WIDTH-1:0]    data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     abort;
  logic                     rdreq_int;

  // An abort marker must stop the read that would otherwise issue in the same cycle.
  assign abort     = rd_d1_q && (cx_in == ABORT_CX);
  assign rdreq_int = (state_q == StRead) && !rdempty && (issued_q < NumPairsW) && !abort;

  always_comb begin
    state_d  = state_q;
    plane_d  = plane_q;
    idx_d    = idx_q;
    issued_d = issued_q;
    to_d     = to_q;
    err_d    = err_q;
    sb_d     = sb_q;
    data_d   = data_q;
    valid_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          data_d   = '0;
          plane_d  = TopPlane;
          idx_d    = '0;
          issued_d = '0;
          to_d     = '0;
          err_d    = 1'b0;
          sb_d     = subband;
          state_d  = StRead;
        end
      end
      StRead, StDrain: begin
        if (rdreq_int) begin
          issued_d = issued_q + 1'b1;
          if (issued_q == LastIss) state_d = StDrain;
        end
        // Timeout counts consecutive empty cycles only while reads are still owed.
        if (state_q == StRead) begin
          if (rdempty) begin
            if (to_q == ToLast) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              to_d = to_q + 1'b1;
            end
          end else begin
            to_d = '0;
          end
        end
        if (rd_d1_q) begin
          if (abort) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            data_d[idx_q][plane_q] = bit_in;
            if (idx_q == 4'd8) begin
              idx_d = '0;
              if (plane_q != '0) plane_d = plane_q - 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
            // Only the final outstanding read can land while draining.
            if (state_q == StDrain) begin
              state_d = StDone;
              valid_d = 1'b1;
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRead) || (state_d == StDrain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      plane_q  <= '0;
      idx_q    <= '0;
      issued_q <= '0;
      to_q     <= '0;
      rd_d1_q  <= 1'b0;
      err_q    <= 1'b0;
      sb_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      plane_q  <= plane_d;
      idx_q    <= idx_d;
      issued_q <= issued_d;
      to_q     <= to_d;
      rd_d1_q  <= rdreq_int;
      err_q    <= err_d;
      sb_q     <= sb_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign rdreq        = rdreq_int;
  assign data0        = data_q[0];
  assign data1        = data_q[1];
  assign data2        = data_q[2];
  assign data3        = data_q[3];
  assign data4        = data_q[4];
  assign data5        = data_q[5];
  assign data6        = data_q[6];
  assign data7        = data_q[7];
  assign data8        = data_q[8];
  assign subband_out  = sb_q;
  assign output_valid = valid_q;
  assign busy         = busy_q;
  assign decode_err   = err_q;

endmodule

// File: tb/tb_bit_plane_decoder.sv
// Scoreboard bench for bit_plane_decoder: a FIFO model feeds decision pairs built from
// random coefficients; expected groups are queued at start and checked by a monitor.

module tb_bit_plane_decoder;

  localparam int W  = 16;
  localparam int TO = 1024;
  localparam int NP = 9 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   subband = 3'd0;
  logic         rdempty = 1'b1;
  logic         rdreq;
  logic         bit_in = 1'b0;
  logic [3:0]   cx_in = 4'd0;
  logic [W-1:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
  logic [2:0]   subband_out;
  logic         output_valid, busy, decode_err;

  typedef logic [8:0][W-1:0] grp_t;
  typedef struct {
    int         kind;  // 0 complete, 1 abort, 2 timeout
    grp_t       data;
    logic [2:0] sb;
  } exp_t;
  typedef struct {
    logic [3:0] cx;
    logic       b;
  } pair_t;

  exp_t  sb_q[$];
  pair_t fifo_q[$];
  int    checks = 0;
  int    failures = 0;
  int    pop_count = 0;
  int    valid_count = 0;
  bit    stall_en = 1'b0;
  grp_t  dout;

  assign dout = {d8, d7, d6, d5, d4, d3, d2, d1, d0};

  bit_plane_decoder #(.WIDTH(W), .TIMEOUT_CYC(TO), .ABORT_CX(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .subband(subband), .rdempty(rdempty),
    .rdreq(rdreq), .bit_in(bit_in), .cx_in(cx_in),
    .data0(d0), .data1(d1), .data2(d2), .data3(d3), .data4(d4), .data5(d5), .data6(d6),
    .data7(d7), .data8(d8), .subband_out(subband_out), .output_valid(output_valid),
    .busy(busy), .decode_err(decode_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Model: coefficients as they stand after the first n pairs of the stream.
  function automatic grp_t partial(input grp_t c, input int n);
    grp_t r;
    int   p, i;
    r = '0;
    for (int k = 0; k < n; k++) begin
      p = W - 1 - k / 9;
      i = k % 9;
      r[i][p] = c[i][p];
    end
    return r;
  endfunction

  function automatic grp_t rand_grp();
    grp_t r;
    for (int i = 0; i < 9; i++) r[i] = W'($urandom);
    return r;
  endfunction

  task automatic chk_zero(input string name);
    chk(name, {dout, subband_out, output_valid, busy, decode_err, rdreq}, '0);
  endtask

  // FIFO model: read issued in a cycle -> q presented just after that edge.
  initial begin
    logic  pop;
    pair_t pr;
    forever begin
      @(negedge clk);
      pop = rdreq;
      if (rdreq) chk("rdreq_while_empty", rdempty, 1'b0);
      @(posedge clk);
      #1;
      if (pop) begin
        if (fifo_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fifo_underflow: got read on empty FIFO required no read");
        end else begin
          pr = fifo_q.pop_front();
          cx_in = pr.cx;
          bit_in = pr.b;
          pop_count++;
        end
      end
      rdempty = (fifo_q.size() == 0) || (stall_en && $urandom_range(2) == 0);
    end
  end

  // Monitor: compares every completed or failed group against the scoreboard.
  initial begin
    logic err_prev;
    int   run;
    exp_t e;
    err_prev = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (output_valid) begin
        valid_count++;
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("valid_kind", e.kind, 0);
          chk("group_data", dout, e.data);
          chk("subband_out", subband_out, e.sb);
        end
      end
      if (decode_err && !err_prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_err", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("err_expected", e.kind != 0, 1'b1);
          chk("partial_data", dout, e.data);
          chk("err_subband", subband_out, e.sb);
          chk("err_busy", busy, 1'b0);
          if (e.kind == 2) chk("timeout_empty_cycles", run, TO);
        end
      end
      err_prev = decode_err;
      run = (busy && rdempty) ? run + 1 : 0;
    end
  end

  task automatic load_stream(input grp_t c, input int n, input int abort_at, input int cx_fix);
    pair_t pr;
    int    p, i;
    fifo_q.delete();
    for (int k = 0; k < n; k++) begin
      p = W - 1 - k / 9;
      i = k % 9;
      pr.b = c[i][p];
      if (k == abort_at) pr.cx = 4'hF;
      else if (cx_fix >= 0) pr.cx = 4'(cx_fix);
      else pr.cx = 4'($urandom_range(14));
      fifo_q.push_back(pr);
    end
  endtask

  task automatic run_group(input grp_t c, input logic [2:0] sbv, input int n_feed,
                           input int abort_at, input int kind, input bit stalls,
                           input bit spam, input int exp_cyc, input int cx_fix);
    exp_t e;
    int   cyc;
    int   vc0;
    bit   done;
    load_stream(c, n_feed, abort_at, cx_fix);
    stall_en = stalls;
    e.kind = kind;
    e.sb = sbv;
    e.data = (kind == 0) ? c : (kind == 1) ? partial(c, abort_at) : partial(c, n_feed);
    sb_q.push_back(e);
    vc0 = valid_count;
    @(posedge clk);
    #1;
    pop_count = 0;
    start = 1'b1;
    subband = sbv;
    @(posedge clk);
    #1;
    start = 1'b0;
    subband = 3'($urandom);
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (output_valid || decode_err || cyc > 6000) done = 1'b1;
      else start = (spam && busy && (cyc % 13 == 4));
    end
    start = 1'b0;
    if (cyc > 6000) chk("group_finished", 1'b0, 1'b1);
    if (kind == 0) begin
      chk("valid_seen", output_valid, 1'b1);
      if (exp_cyc > 0) chk("valid_latency", cyc, exp_cyc);
      chk("read_pulses", pop_count, NP);
      if (spam) start = 1'b1;  // lands on the DONE cycle and must be ignored
      @(negedge clk);
      start = 1'b0;
      chk("valid_one_cycle", output_valid, 1'b0);
      chk("valid_pulses", valid_count - vc0, 1);
      chk("idle_after_done", busy, 1'b0);
    end else begin
      chk("err_seen", decode_err, 1'b1);
      repeat (4) @(negedge clk);
      chk("err_sticky", decode_err, 1'b1);
      chk("no_valid_on_err", valid_count - vc0, 0);
      chk("idle_after_err", busy, 1'b0);
    end
  endtask

  initial begin
    grp_t c;
    int   guard;
    // 1: reset
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("after_release");

    // 2: nominal LL group with the reference coefficients
    c[0] = 16'd50;  c[1] = 16'd211; c[2] = 16'd150;
    c[3] = 16'd54;  c[4] = 16'd241; c[5] = 16'd156;
    c[6] = 16'd52;  c[7] = 16'd242; c[8] = 16'd117;
    run_group(c, 3'd0, NP, -1, 0, 1'b0, 1'b0, NP + 2, 3);

    // 3: same stream with FIFO stalls and start pulses while busy
    run_group(c, 3'd0, NP, -1, 0, 1'b1, 1'b1, -1, 3);

    // 4: abort marker at pair 20, then a clean HL2 group
    run_group(rand_grp(), 3'd5, NP, 20, 1, 1'b0, 1'b0, -1, -1);
    fifo_q.delete();
    run_group(rand_grp(), 3'd2, NP, -1, 0, 1'b1, 1'b0, -1, -1);

    // 5: feed stops after pair 50
    run_group(rand_grp(), 3'd4, 51, -1, 2, 1'b0, 1'b0, -1, -1);

    // 6: reset mid-group at pair 70 with extra starts while busy
    c = rand_grp();
    load_stream(c, NP, -1, -1);
    stall_en = 1'b0;
    @(posedge clk);
    #1;
    pop_count = 0;
    start = 1'b1;
    subband = 3'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (pop_count < 70 && guard < 1000) begin
      @(negedge clk);
      guard++;
      start = (guard % 7 == 3);
    end
    start = 1'b0;
    chk("reached_pair_70", pop_count >= 70, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("reset_mid_group");
    fifo_q.delete();
    repeat (3) @(negedge clk);
    chk_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("reset_released");
    run_group(rand_grp(), 3'd1, NP, -1, 0, 1'b0, 1'b1, NP + 2, -1);

    // random groups with stalls
    for (int g = 0; g < 3; g++) begin
      run_group(rand_grp(), 3'($urandom_range(6)), NP, -1, 0, 1'b1, 1'b1, -1, -1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
